// File: rtl/reg_file_p.sv
// ---------------------------------------------------------------------------
// reg_file_p
//
// Purpose:
//   Multi-ported register file: one write port, two combinational read ports.
//   Register 0 can be tied to zero, and a same-cycle write can be forwarded to
//   the read ports. A soft-clear request sweeps every entry to zero, one entry
//   per clock, while Busy is high. Dirty tracks which entries have been written
//   since they were last cleared.
//
// Ports:
//   CLK        in   1       clock, all state updates on the rising edge
//   RST        in   1       asynchronous active-low reset
//   RegWre     in   1       write enable (ignored while Busy)
//   WriteReg   in   ADDR_W  write address
//   WriteData  in   DATA_W  write data
//   ReadReg1   in   ADDR_W  read address, port 1
//   ReadReg2   in   ADDR_W  read address, port 2
//   ReadData1  out  DATA_W  combinational read data, port 1
//   ReadData2  out  DATA_W  combinational read data, port 2
//   ClrReq     in   1       soft-clear request, sampled on the clock edge
//   Busy       out  1       high while the clear sweep is running
//   Dirty      out  DEPTH   bit i set when register i written since last clear
// ---------------------------------------------------------------------------
module reg_file_p #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = 32'sd2 ** ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              ClrReq,
    output logic              Busy,
    output logic [DEPTH-1:0]  Dirty
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 32'sd1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1'b1);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  dirty_r;
    logic              wr_en_s;

    // Resolve one read port: zero register first, then forwarding, then array.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] entry,
        input logic              fwd,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] val;
        if ((ZERO_REG != 32'sd0) && (addr == ZERO_IDX)) begin
            val = {DATA_W{1'b0}};
        end else if ((BYPASS != 32'sd0) && fwd && (addr == waddr)) begin
            val = wdata;
        end else begin
            val = entry;
        end
        return val;
    endfunction

    // Qualify the write: only in IDLE, and never into a hard-wired zero register.
    // The same qualifier gates forwarding, so nothing is bypassed during a sweep.
    always_comb begin
        wr_en_s = 1'b0;
        if (RegWre && (state_r == ST_IDLE)) begin
            if ((ZERO_REG != 32'sd0) && (WriteReg == ZERO_IDX)) begin
                wr_en_s = 1'b0;
            end else begin
                wr_en_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state and sweep-counter logic for the soft-clear FSM.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (ClrReq) begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = ZERO_IDX;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_CLEAR: begin
                // ClrReq is deliberately not looked at here: a sweep never restarts.
                if (cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = cnt_r;   // hold rather than wrap
                end else begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = cnt_r + ONE_IDX;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = ZERO_IDX;
            end
        endcase
    end

    // FSM state and sweep counter registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= ZERO_IDX;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Register array and dirty bits: write in IDLE, zero one entry per sweep edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 32'sd0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            dirty_r <= {DEPTH{1'b0}};
        end else if (wr_en_s) begin
            regs_r[WriteReg]  <= WriteData;
            dirty_r[WriteReg] <= 1'b1;
        end else if (state_r == ST_CLEAR) begin
            regs_r[cnt_r]  <= {DATA_W{1'b0}};
            dirty_r[cnt_r] <= 1'b0;
        end else begin
            dirty_r <= dirty_r;
        end
    end

    // Combinational read ports.
    always_comb begin
        ReadData1 = read_port(ReadReg1, regs_r[ReadReg1], wr_en_s, WriteReg, WriteData);
        ReadData2 = read_port(ReadReg2, regs_r[ReadReg2], wr_en_s, WriteReg, WriteData);
    end

    // Status outputs come straight from state flops.
    always_comb begin
        Busy  = (state_r == ST_CLEAR);
        Dirty = dirty_r;
    end

endmodule

// File: tb/tb_reg_file_p.sv
// ---------------------------------------------------------------------------
// tb_reg_file_p
//
// Two instances share all inputs: inst 0 uses the defaults (ZERO_REG=1,
// BYPASS=1), inst 1 uses ZERO_REG=0, BYPASS=0. A behavioural model tracks the
// register contents, dirty set and remaining sweep for each, and a compare
// process checks every output of both on every falling clock edge. Directed
// scenarios with literal expectations come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_reg_file_p;

    logic        CLK;
    logic        RST;
    logic        RegWre;
    logic [2:0]  WriteReg;
    logic [15:0] WriteData;
    logic [2:0]  ReadReg1;
    logic [2:0]  ReadReg2;
    logic        ClrReq;

    logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, busy_b;
    logic [7:0]  dirty_a, dirty_b;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    reg_file_p #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .CLK(CLK), .RST(RST), .RegWre(RegWre), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_a), .ReadData2(rd2_a), .ClrReq(ClrReq),
        .Busy(busy_a), .Dirty(dirty_a)
    );

    reg_file_p #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .CLK(CLK), .RST(RST), .RegWre(RegWre), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_b), .ReadData2(rd2_b), .ClrReq(ClrReq),
        .Busy(busy_b), .Dirty(dirty_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- behavioural model ----------------
    logic [15:0] m_regs [2][8];
    logic [7:0]  m_dirty [2];
    logic        m_busy [2];
    int          m_pos [2];   // next entry the sweep will zero

    function automatic bit has_zero_reg(int k);
        return (k == 0);
    endfunction

    function automatic bit has_bypass(int k);
        return (k == 0);
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 8; i++) m_regs[k][i] <= 16'h0000;
                m_dirty[k] <= 8'h00;
                m_busy[k]  <= 1'b0;
                m_pos[k]   <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_busy[k]) begin
                    if (RegWre && !(has_zero_reg(k) && WriteReg == 3'd0)) begin
                        m_regs[k][WriteReg]  <= WriteData;
                        m_dirty[k][WriteReg] <= 1'b1;
                    end
                    if (ClrReq) begin
                        m_busy[k] <= 1'b1;
                        m_pos[k]  <= 0;
                    end
                end else begin
                    m_regs[k][m_pos[k]]  <= 16'h0000;
                    m_dirty[k][m_pos[k]] <= 1'b0;
                    if (m_pos[k] == 7) m_busy[k] <= 1'b0;
                    m_pos[k] <= m_pos[k] + 1;
                end
            end
        end
    end

    function automatic logic [15:0] exp_read(int k, logic [2:0] a);
        if (has_zero_reg(k) && a == 3'd0) return 16'h0000;
        if (has_bypass(k) && RegWre && !m_busy[k] && a == WriteReg) return WriteData;
        return m_regs[k][a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("a_rd1",   {16'h0, rd1_a},  {16'h0, exp_read(0, ReadReg1)});
            chk("a_rd2",   {16'h0, rd2_a},  {16'h0, exp_read(0, ReadReg2)});
            chk("a_busy",  {31'h0, busy_a}, {31'h0, m_busy[0]});
            chk("a_dirty", {24'h0, dirty_a}, {24'h0, m_dirty[0]});
            chk("b_rd1",   {16'h0, rd1_b},  {16'h0, exp_read(1, ReadReg1)});
            chk("b_rd2",   {16'h0, rd2_b},  {16'h0, exp_read(1, ReadReg2)});
            chk("b_busy",  {31'h0, busy_b}, {31'h0, m_busy[1]});
            chk("b_dirty", {24'h0, dirty_b}, {24'h0, m_dirty[1]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        RegWre = 1'b0; ClrReq = 1'b0;
        WriteReg = 3'd0; WriteData = 16'h0000;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        RegWre = 1'b1; WriteReg = a; WriteData = d;
        step();
        RegWre = 1'b0;
    endtask

    task automatic fill_regs();
        for (int i = 1; i < 8; i++) write_reg(3'(i), 16'(i * 32'h1111));
    endtask

    // Pulse ClrReq, optionally re-pulse it at sweep cycle pulse_at, count Busy cycles.
    task automatic run_clear(input int pulse_at, output int cycles);
        ClrReq = 1'b1;
        step();
        ClrReq = 1'b0;
        cycles = 0;
        while (busy_a && cycles < 20) begin
            ClrReq = (cycles == pulse_at);
            cycles++;
            step();
        end
        ClrReq = 1'b0;
    endtask

    int cyc;

    initial begin
        RST = 1'b0;
        idle_inputs();
        ReadReg1 = 3'd0; ReadReg2 = 3'd0;
        @(posedge CLK);
        #1;
        cmp_en = 1'b1;
        chk("rst_busy",  {31'h0, busy_a}, 32'h0);
        chk("rst_dirty", {24'h0, dirty_a}, 32'h0);
        chk("rst_rd1",   {16'h0, rd1_a}, 32'h0);
        step();
        RST = 1'b1;

        // write R3 then read it back
        write_reg(3'd3, 16'h1234);
        ReadReg1 = 3'd3;
        #1;
        chk("r3_read",  {16'h0, rd1_a}, 32'h1234);
        chk("r3_dirty", {24'h0, dirty_a}, 32'h08);

        // same-cycle forwarding vs. pre-edge value
        RegWre = 1'b1; WriteReg = 3'd5; WriteData = 16'hBEEF; ReadReg2 = 3'd5;
        #1;
        chk("byp_on",  {16'h0, rd2_a}, 32'hBEEF);
        chk("byp_off", {16'h0, rd2_b}, 32'h0000);
        step();
        RegWre = 1'b0;

        // zero register
        write_reg(3'd0, 16'hFFFF);
        ReadReg1 = 3'd0;
        #1;
        chk("r0_zero",    {16'h0, rd1_a}, 32'h0000);
        chk("r0_dirty",   {31'h0, dirty_a[0]}, 32'h0);
        chk("r0_nonzero", {16'h0, rd1_b}, 32'hFFFF);

        // full sweep: R6 holds until its edge, writes during Busy ignored
        fill_regs();
        ReadReg1 = 3'd6;
        ClrReq = 1'b1;
        step();
        ClrReq = 1'b0;
        RegWre = 1'b1; WriteReg = 3'd2; WriteData = 16'hAAAA;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk("sweep_busy", {31'h0, busy_a}, 32'h1);
            chk("sweep_r6",   {16'h0, rd1_a}, (j >= 7) ? 32'h0000 : 32'h6666);
            step();
        end
        RegWre = 1'b0;
        #1;
        chk("sweep_done",  {31'h0, busy_a}, 32'h0);
        chk("sweep_dirty", {24'h0, dirty_a}, 32'h00);
        ReadReg1 = 3'd2;
        #1;
        chk("sweep_r2", {16'h0, rd1_a}, 32'h0000);

        // re-request during sweep does not extend it
        fill_regs();
        run_clear(3, cyc);
        chk("clr_len", cyc, 32'd8);

        // clear request together with a write: the write lands, then is swept
        RegWre = 1'b1; WriteReg = 3'd4; WriteData = 16'h4242; ClrReq = 1'b1;
        step();
        RegWre = 1'b0; ClrReq = 1'b0;
        ReadReg1 = 3'd4;
        #1;
        chk("wr_clr_r4", {16'h0, rd1_a}, 32'h4242);
        for (int j = 0; j < 8; j++) step();
        chk("wr_clr_end", {16'h0, rd1_a}, 32'h0000);

        // asynchronous reset mid-sweep
        fill_regs();
        ReadReg1 = 3'd7;
        ClrReq = 1'b1;
        step();
        ClrReq = 1'b0;
        for (int j = 0; j < 4; j++) step();
        #1;
        RST = 1'b0;
        #1;
        chk("arst_busy",  {31'h0, busy_a}, 32'h0);
        chk("arst_r7",    {16'h0, rd1_a}, 32'h0000);
        chk("arst_dirty", {24'h0, dirty_a}, 32'h00);
        step();
        RST = 1'b1;
        write_reg(3'd4, 16'h4444);
        ReadReg1 = 3'd4;
        #1;
        chk("post_rst_wr", {16'h0, rd1_a}, 32'h4444);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            RegWre    = ($urandom_range(0, 9) < 6);
            WriteReg  = 3'($urandom_range(0, 7));
            WriteData = 16'($urandom);
            ReadReg1  = ($urandom_range(0, 9) < 3) ? WriteReg : 3'($urandom_range(0, 7));
            ReadReg2  = ($urandom_range(0, 9) < 3) ? WriteReg : 3'($urandom_range(0, 7));
            ClrReq    = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 299) == 0) RST = 1'b0;
            else RST = 1'b1;
            step();
        end
        RST = 1'b1;
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
